sort_result_buf: RTL and testbench



---
 rtl/sort_result_buf.sv | 189 ++++++++++++++++++
 tb/tb_sort_result_buf.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_result_buf.sv
`default_nettype none
// ============================================================================
//  Module   : sort_result_buf
//  Brief    : Captures one sorted AXI-Stream frame into a local buffer, checks
//             non-decreasing signed order, and exposes buffer, count and status
//             over AXI-Lite. Optional irq output under `SORT_BUF_IRQ_EN.
//  Revision : 1.0
// ============================================================================
module sort_result_buf #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
`ifdef SORT_BUF_IRQ_EN
    output logic                   irq,
`endif
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata
);

    localparam int               c_IDX_W       = $clog2(DEPTH);
    localparam logic [5:0]       c_DEPTH_CNT   = 6'(DEPTH);
    localparam logic [0:0]       c_ST_CAPTURE  = 1'b0;
    localparam logic [0:0]       c_ST_DONE     = 1'b1;
    localparam logic [pADDR_WIDTH-1:0] c_ADDR_CTRL    = pADDR_WIDTH'(32'h00);
    localparam logic [pADDR_WIDTH-1:0] c_ADDR_COUNT   = pADDR_WIDTH'(32'h04);
    localparam logic [pADDR_WIDTH-1:0] c_ADDR_DEPTH   = pADDR_WIDTH'(32'h08);
    localparam logic [pADDR_WIDTH-1:0] c_ADDR_BUF     = pADDR_WIDTH'(32'h40);
    localparam logic [pADDR_WIDTH-1:0] c_ADDR_BUF_END = pADDR_WIDTH'(64 + 4 * DEPTH);

    logic [0:0]             r_state;
    logic [5:0]             r_count;
    logic                   r_done;
    logic                   r_ovf;
    logic                   r_oerr;
    logic [pDATA_WIDTH-1:0] r_prev;
    logic                   r_prev_valid;
    logic                   r_irq;
    logic [pDATA_WIDTH-1:0] r_buf [DEPTH];

    logic                   r_awready;
    logic                   r_arready;
    logic                   r_rvalid;
    logic [pDATA_WIDTH-1:0] r_rdata;

    logic                   w_accept;
    logic                   w_wr_hs;
    logic                   w_clear;
    logic                   w_room;
    logic                   w_irq_bit;
    logic [pDATA_WIDTH-1:0] w_status;
    logic [pDATA_WIDTH-1:0] w_rdata_nxt;
    logic [pADDR_WIDTH-1:0] w_buf_off;
    logic                   w_unused;

    assign ss_tready = (r_state == c_ST_CAPTURE);
    assign awready   = r_awready;
    assign wready    = r_awready;
    assign arready   = r_arready;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;

    assign w_accept = ss_tvalid & ss_tready;
    assign w_wr_hs  = r_awready & awvalid & wvalid;
    assign w_clear  = w_wr_hs & (awaddr == c_ADDR_CTRL) & wdata[0];
    assign w_room   = (r_count < c_DEPTH_CNT);

`ifdef SORT_BUF_IRQ_EN
    assign irq       = r_irq;
    assign w_irq_bit = r_irq;
`else
    assign w_irq_bit = 1'b0;
`endif

    assign w_unused = ^{wdata[pDATA_WIDTH-1:1], w_buf_off, r_irq};

    // Capture FSM, flags and order check; a clear always wins over an accept
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state      <= c_ST_CAPTURE;
            r_count      <= '0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_oerr       <= 1'b0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_irq        <= 1'b0;
        end else if (w_clear) begin
            r_state      <= c_ST_CAPTURE;
            r_count      <= '0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_oerr       <= 1'b0;
            r_prev_valid <= 1'b0;
            r_irq        <= 1'b0;
        end else if (w_accept) begin
            if (w_room) begin
                r_count <= r_count + 6'd1;
            end else begin
                r_ovf <= 1'b1;
            end
            if (r_prev_valid && ($signed(ss_tdata) < $signed(r_prev))) begin
                r_oerr <= 1'b1;
            end
            r_prev       <= ss_tdata;
            r_prev_valid <= 1'b1;
            if (ss_tlast) begin
                r_state <= c_ST_DONE;
                r_done  <= 1'b1;
                r_irq   <= 1'b1;
            end
        end
    end

    // Buffer storage carries no reset; contents past count are stale by design
    always_ff @(posedge axis_clk) begin
        if (w_accept && !w_clear && w_room) begin
            r_buf[r_count[c_IDX_W-1:0]] <= ss_tdata;
        end
    end

    always_comb begin
        w_status    = '0;
        w_status[1] = r_done;
        w_status[2] = (r_count == 6'd0);
        w_status[3] = r_ovf;
        w_status[4] = r_oerr;
        w_status[5] = w_irq_bit;
    end

    always_comb begin
        w_rdata_nxt = '0;
        w_buf_off   = araddr - c_ADDR_BUF;
        if (araddr == c_ADDR_CTRL) begin
            w_rdata_nxt = w_status;
        end else if (araddr == c_ADDR_COUNT) begin
            w_rdata_nxt = pDATA_WIDTH'(r_count);
        end else if (araddr == c_ADDR_DEPTH) begin
            w_rdata_nxt = pDATA_WIDTH'(DEPTH);
        end else if ((araddr >= c_ADDR_BUF) && (araddr < c_ADDR_BUF_END) &&
                     (araddr[1:0] == 2'b00)) begin
            w_rdata_nxt = r_buf[w_buf_off[c_IDX_W+1:2]];
        end
    end

    // Write channel: single-cycle awready/wready pulse once both valids are up
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_awready <= 1'b0;
        end else begin
            r_awready <= awvalid & wvalid & ~r_awready;
        end
    end

    // Read channel: one outstanding read, data frozen while rvalid is held
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= arvalid & ~r_rvalid & ~r_arready;
            if (r_arready && arvalid) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata_nxt;
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort_result_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sort_result_buf
//  Brief    : Directed scoreboard bench for sort_result_buf.
//  Revision : 1.0
// ============================================================================
module tb_sort_result_buf;

`ifdef SORT_BUF_IRQ_EN
    localparam logic [31:0] c_IRQ = 32'h20;
`else
    localparam logic [31:0] c_IRQ = 32'h00;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss_tvalid = 1'b0;
    logic [31:0] ss_tdata = '0;
    logic        ss_tlast = 1'b0;
    logic        ss_tready;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [11:0] awaddr = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] wdata = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [11:0] araddr = '0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] rdata;
`ifdef SORT_BUF_IRQ_EN
    logic        irq;
`endif

    sort_result_buf #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .DEPTH(16)) dut (
        .axis_clk  (clk),
        .axis_rst_n(rst_n),
`ifdef SORT_BUF_IRQ_EN
        .irq       (irq),
`endif
        .ss_tvalid (ss_tvalid),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .ss_tready (ss_tready),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_q [$];
    string       nm_q [$];
    logic [31:0] mon_exp;
    string       mon_nm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_total++;
        $display("FAIL %s: got timeout expected DUT response", nm);
    endtask

    // Monitor: every completed read beat is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_read: got 0x%08h expected no read", rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_nm  = nm_q.pop_front();
                chk(mon_nm, rdata, mon_exp);
            end
        end
    end

    task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp,
                            input string nm, input bit hold);
        int cyc;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        rready  = !hold;
        araddr  = addr;
        arvalid = 1'b1;
        cyc     = 0;
        @(negedge clk);
        while (!arready && cyc < 20) begin cyc++; @(negedge clk); end
        if (!arready) begin
            timeout({nm, "_arready"});
            void'(exp_q.pop_back()); void'(nm_q.pop_back());
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!rvalid && cyc < 20) begin cyc++; @(negedge clk); end
        if (!rvalid) begin
            timeout({nm, "_rvalid"});
            void'(exp_q.pop_back()); void'(nm_q.pop_back());
            return;
        end
        if (!hold) begin @(posedge clk); #1; end
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data);
        int cyc;
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        cyc     = 0;
        @(negedge clk);
        while (!(awready && wready) && cyc < 20) begin cyc++; @(negedge clk); end
        if (!(awready && wready)) timeout("write_ready");
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] vals [$], input bit do_last, output int stalls);
        int cyc;
        stalls = 0;
        for (int i = 0; i < vals.size(); i++) begin
            ss_tvalid = 1'b1;
            ss_tdata  = vals[i];
            ss_tlast  = do_last && (i == vals.size() - 1);
            cyc = 0;
            @(negedge clk);
            while (!ss_tready && cyc < 20) begin stalls++; cyc++; @(negedge clk); end
            if (!ss_tready) begin timeout("stream_tready"); break; end
            @(posedge clk); #1;
        end
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] q [$];
        int          stalls;
        int          held;
        logic [31:0] first_rd;
        bit          stable;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 32'(ss_tready), 32'd1);
        chk("rst_awready", 32'(awready | wready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(12'h000, 32'h4 | 32'h0, "rst_status", 0);
        axi_read(12'h004, 32'd0, "rst_count", 0);
        axi_read(12'h008, 32'd16, "depth_reg", 0);

        // Ascending 11-word frame
        q.delete();
        for (int i = 1; i <= 11; i++) q.push_back(32'(i));
        send_frame(q, 1'b1, stalls);
        chk("t1_tready_after_last", 32'(ss_tready), 32'd0);
        chk("t1_no_stall", 32'(stalls), 32'd0);
        axi_read(12'h000, 32'h2 | c_IRQ, "t1_status", 0);
        axi_read(12'h004, 32'd11, "t1_count", 0);
        for (int i = 0; i < 11; i++) axi_read(12'(32'h40 + 4 * i), 32'(i + 1), "t1_buf", 0);
`ifdef SORT_BUF_IRQ_EN
        chk("t1_irq", 32'(irq), 32'd1);
`endif

        // Descending frame trips the order check
        axi_write(12'h000, 32'h1);
        q.delete();
        for (int i = 11; i >= 1; i--) q.push_back(32'(i));
        send_frame(q, 1'b1, stalls);
        axi_read(12'h000, 32'h12 | c_IRQ, "t2_status", 0);
        axi_read(12'h004, 32'd11, "t2_count", 0);
        axi_read(12'h040, 32'd11, "t2_buf0", 0);

        // Overflow: 20 words into 16 entries
        axi_write(12'h000, 32'h1);
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(32'(i));
        send_frame(q, 1'b1, stalls);
        chk("t3_no_stall", 32'(stalls), 32'd0);
        axi_read(12'h004, 32'd16, "t3_count", 0);
        axi_read(12'h000, 32'h0A | c_IRQ, "t3_status", 0);
        axi_read(12'h07C, 32'd15, "t3_buf15", 0);
        axi_read(12'h080, 32'd0, "t3_past_buf", 0);
        axi_read(12'h00C, 32'd0, "t3_unmapped", 0);

        // Clear from DONE, then a frame with equal neighbours
        axi_write(12'h000, 32'h1);
        chk("t4_tready_after_clear", 32'(ss_tready), 32'd1);
`ifdef SORT_BUF_IRQ_EN
        chk("t4_irq_cleared", 32'(irq), 32'd0);
`endif
        axi_read(12'h000, 32'h4, "t4_status_empty", 0);
        axi_read(12'h004, 32'd0, "t4_count_zero", 0);
        q = '{32'd5, 32'd5, 32'd7};
        send_frame(q, 1'b1, stalls);
        axi_read(12'h000, 32'h2 | c_IRQ, "t4_status", 0);
        axi_read(12'h004, 32'd3, "t4_count", 0);

        // Read held off by rready low for 5 cycles
        axi_read(12'h044, 32'd5, "t5_hold_read", 1);
        held = 0;
        stable = 1'b1;
        first_rd = rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rvalid) held++;
            if (rdata !== first_rd) stable = 1'b0;
        end
        chk("t5_rvalid_held", 32'(held), 32'd5);
        chk("t5_rdata_stable", 32'(stable), 32'd1);
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;

        // Reset after 4 of 11 words
        axi_write(12'h000, 32'h1);
        q.delete();
        for (int i = 1; i <= 4; i++) q.push_back(32'(i));
        send_frame(q, 1'b0, stalls);
        axi_read(12'h004, 32'd4, "t6_count_pre_rst", 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rdata", rdata, 32'd0);
        chk("t6_rst_rvalid_arready", 32'({rvalid, arready, awready, wready}), 32'd0);
        chk("t6_rst_tready", 32'(ss_tready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(12'h000, 32'h4, "t6_status_after_rst", 0);
        q.delete();
        for (int i = 1; i <= 11; i++) q.push_back(32'(i));
        send_frame(q, 1'b1, stalls);
        axi_read(12'h004, 32'd11, "t6_count", 0);
        axi_read(12'h000, 32'h2 | c_IRQ, "t6_status", 0);
`ifdef SORT_BUF_IRQ_EN
        chk("t6_irq_set", 32'(irq), 32'd1);
        axi_write(12'h000, 32'h1);
        chk("t6_irq_clear", 32'(irq), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
